collision_scan_mux: RTL and testbench
=====================================

Name: collision_scan_mux

Overview:
- Parametrised, registered N:1 collision-bit selector with a sequential scan engine.
- Direct mode: registered single-bit select from the collision data bus, one cycle latency.
- Scan mode: on Start, snapshots the bus and walks every bit, one per clock. Reports hit flag, lowest set index and set-bit count.
- Sits in the JUEGO/COLISION path between the lane/object-occupancy buses and the game-control FSM.

Parameters:
- DATAWIDTH_SELECTOR, 4: select/index width.
- DATAWIDTH_DATA, 16: number of data bits N. Must satisfy N <= 2^DATAWIDTH_SELECTOR and N >= 2.

Ports:
- ColScan_CLOCK_50  in  1  single system clock; all state changes on the rising edge.
- ColScan_RESET_InHigh  in  1  synchronous, active-high reset.
- ColScan_Mode_In  in  1  0 = direct select, 1 = scan enabled.
- ColScan_Start_In  in  1  scan request, level-sampled.
- ColScan_Select_Bus_In  in  DATAWIDTH_SELECTOR  direct-mode bit select.
- ColScan_Data_Bus_In  in  DATAWIDTH_DATA  collision/occupancy bits.
- ColScan_Z_Bit_Out  out  1  registered selected bit.
- ColScan_Busy_Out  out  1  high while scanning.
- ColScan_Done_Out  out  1  one-cycle pulse; scan results valid.
- ColScan_Hit_Out  out  1  at least one set bit in the snapshot.
- ColScan_Index_Bus_Out  out  DATAWIDTH_SELECTOR  lowest set-bit index.
- ColScan_Count_Bus_Out  out  DATAWIDTH_SELECTOR+1  number of set bits.

Behaviour:
- Reset:
  - Synchronous; when RESET_InHigh=1 at an edge, all outputs are 0 next cycle, FSM goes to IDLE, snapshot and scan index are cleared.
  - Reset overrides every other input, including mid-scan; a partial scan is discarded with no Done pulse.
- Z_Bit_Out:
  - Every edge (not in reset), Z_Bit_Out <= Data_Bus_In[Select_Bus_In] when Select_Bus_In < N, else 0.
  - Live bus is used; latency is 1 cycle.
  - Updated in both modes and in every FSM state.
- FSM has three states: IDLE, SCAN, DONE.
- IDLE:
  - If Mode_In=1 and Start_In=1 at an edge: snapshot <= Data_Bus_In, idx <= 0, Hit/Index/Count cleared to 0, go to SCAN.
  - Start_In with Mode_In=0 is ignored.
- SCAN:
  - Busy_Out=1.
  - Each edge examines snapshot[idx]. If set: Count <= Count+1; if Hit was 0, Index <= idx and Hit <= 1.
  - idx increments by 1 per edge. After examining idx=N-1, go to DONE; idx does not wrap.
  - Examination takes exactly N edges.
  - Data_Bus_In changes, Start_In and Mode_In are ignored during SCAN. Mode is only checked at start.
- DONE:
  - Done_Out=1 for exactly one cycle, Busy_Out=0. Next edge goes to IDLE unconditionally; Start_In asserted in DONE is ignored.
- Timing: Start sampled at edge k gives Busy high for cycles k+1..k+N and Done high in cycle k+N+1. The earliest accepted restart is edge k+N+2.
- Result hold: Hit/Index/Count hold their values from DONE onward until the next accepted Start or reset.
- No hit: Hit=0, Index=0, Count=0.
- Arithmetic: Count is unsigned and cannot overflow; max N fits in DATAWIDTH_SELECTOR+1 bits. Index is the lowest set position (LSB priority).
- All-ones snapshot: Count=N, Index=0.
- Start held high continuously: a new scan begins every N+2 cycles.

Test Plan:
- Reset/idle: assert RESET_InHigh 2 cycles mid-operation -> all outputs 0 next cycle, FSM IDLE, no Done pulse.
- Direct select: Mode=0, Data=16'hA5C3, Select sweeps 0..15 -> Z_Bit_Out one cycle later equals bit Select (bit0=1, bit2=0, bit15=1). Start pulses produce no Busy.
- Basic scan: Mode=1, Data=16'h0120, Start pulse at edge k -> Busy high 16 cycles, Done at k+17, Hit=1, Index=5, Count=2. Results held 5 cycles after Done.
- Boundaries:
  - Data=16'h0000 -> Hit=0, Index=0, Count=0.
  - Data=16'hFFFF -> Hit=1, Index=0, Count=16.
  - Data=16'h8000 -> Index=15, Count=1.
- Snapshot/ignore rules: start scan on 16'h0008, change Data to 16'hFFFF and pulse Start during SCAN and DONE -> results Index=3, Count=1, exactly one Done pulse.
- Reset mid-scan then restart: reset at scan cycle 7, then Start on 16'h0300 -> clean scan, Index=8, Count=2, Done exactly N+1 cycles after Start.

Source files
------------

// File: rtl/collision_scan_mux.sv
// Registered N:1 collision-bit selector with a one-bit-per-clock scan engine.
// Scan reports hit flag, lowest set index and population count of a snapshot.
module collision_scan_mux #(
  parameter int DATAWIDTH_SELECTOR = 4,
  parameter int DATAWIDTH_DATA     = 16
) (
  input  logic                          ColScan_CLOCK_50,
  input  logic                          ColScan_RESET_InHigh,
  input  logic                          ColScan_Mode_In,
  input  logic                          ColScan_Start_In,
  input  logic [DATAWIDTH_SELECTOR-1:0] ColScan_Select_Bus_In,
  input  logic [DATAWIDTH_DATA-1:0]     ColScan_Data_Bus_In,
  output logic                          ColScan_Z_Bit_Out,
  output logic                          ColScan_Busy_Out,
  output logic                          ColScan_Done_Out,
  output logic                          ColScan_Hit_Out,
  output logic [DATAWIDTH_SELECTOR-1:0] ColScan_Index_Bus_Out,
  output logic [DATAWIDTH_SELECTOR:0]   ColScan_Count_Bus_Out
);

  localparam int SW = DATAWIDTH_SELECTOR;
  localparam int N  = DATAWIDTH_DATA;
  localparam int P  = 2 ** SW;

  localparam logic [SW-1:0] LAST    = SW'(N - 1);
  localparam logic [SW-1:0] IDX_ONE = SW'(1);
  localparam logic [SW:0]   CNT_ONE = (SW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]  snap_q, snap_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [SW-1:0] index_q, index_d;
  logic [SW:0]   count_q, count_d;
  logic          hit_q, hit_d;
  logic          z_q, z_d;

  // Zero-padded to the full select range so an out-of-range select reads 0.
  logic [P-1:0] live_pad;
  logic [P-1:0] snap_pad;
  logic         scan_bit;

  assign live_pad = P'(ColScan_Data_Bus_In);
  assign snap_pad = P'(snap_q);
  assign scan_bit = snap_pad[idx_q];

  always_ff @(posedge ColScan_CLOCK_50) begin
    if (ColScan_RESET_InHigh) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      index_q <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      index_q <= index_d;
      count_q <= count_d;
      hit_q   <= hit_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    index_d = index_q;
    count_d = count_q;
    hit_d   = hit_q;
    z_d     = live_pad[ColScan_Select_Bus_In];

    unique case (state_q)
      IDLE: begin
        if (ColScan_Mode_In && ColScan_Start_In) begin
          state_d = SCAN;
          snap_d  = ColScan_Data_Bus_In;
          idx_d   = '0;
          index_d = '0;
          count_d = '0;
          hit_d   = 1'b0;
        end
      end
      SCAN: begin
        if (scan_bit) begin
          count_d = count_q + CNT_ONE;
          if (!hit_q) begin
            hit_d   = 1'b1;
            index_d = idx_q;
          end
        end
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ColScan_Z_Bit_Out     = z_q;
  assign ColScan_Busy_Out      = (state_q == SCAN);
  assign ColScan_Done_Out      = (state_q == DONE);
  assign ColScan_Hit_Out       = hit_q;
  assign ColScan_Index_Bus_Out = index_q;
  assign ColScan_Count_Bus_Out = count_q;

endmodule

// File: tb/tb_collision_scan_mux.sv
// Bench for collision_scan_mux: timeline model checked every cycle
// plus directed scans with hand-computed results.
module tb_collision_scan_mux;

  localparam int W = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic         start;
  logic [W-1:0] sel;
  logic [N-1:0] data;
  logic         z;
  logic         busy;
  logic         done;
  logic         hit;
  logic [W-1:0] index;
  logic [W:0]   count;

  int n_pass  = 0;
  int n_total = 0;

  collision_scan_mux #(
    .DATAWIDTH_SELECTOR(W),
    .DATAWIDTH_DATA(N)
  ) dut (
    .ColScan_CLOCK_50(clk),
    .ColScan_RESET_InHigh(rst),
    .ColScan_Mode_In(mode),
    .ColScan_Start_In(start),
    .ColScan_Select_Bus_In(sel),
    .ColScan_Data_Bus_In(data),
    .ColScan_Z_Bit_Out(z),
    .ColScan_Busy_Out(busy),
    .ColScan_Done_Out(done),
    .ColScan_Hit_Out(hit),
    .ColScan_Index_Bus_Out(index),
    .ColScan_Count_Bus_Out(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Results over the lowest m bits of a snapshot.
  task automatic prefix(input logic [N-1:0] v, input int m,
                        output int h, output int ix, output int c);
    h = 0; ix = 0; c = 0;
    for (int i = 0; i < m; i++) begin
      if (v[i]) begin
        if (h == 0) ix = i;
        h = 1;
        c++;
      end
    end
  endtask

  // Timeline model: edge number of the last accepted start decides everything.
  int           e_num = 0;
  int           s_num = -1;
  logic [N-1:0] m_snap = '0;
  int           ez, eb, ed, eh, ei, ec, dd;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        s_num  = -1;
        m_snap = '0;
        ez     = 0;
      end else begin
        ez = (int'(sel) < N) ? int'(data[sel]) : 0;
        if (mode && start && (s_num < 0 || e_num - s_num >= N + 2)) begin
          s_num  = e_num;
          m_snap = data;
        end
      end
      if (s_num < 0) begin
        eb = 0; ed = 0; eh = 0; ei = 0; ec = 0;
      end else begin
        dd = e_num - s_num;
        eb = (dd < N) ? 1 : 0;
        ed = (dd == N) ? 1 : 0;
        prefix(m_snap, (dd < N) ? dd : N, eh, ei, ec);
      end
      e_num++;
      #1;
      chk("z", int'(z), ez);
      chk("busy", int'(busy), eb);
      chk("done", int'(done), ed);
      chk("hit", int'(hit), eh);
      chk("index", int'(index), ei);
      chk("count", int'(count), ec);
    end
  end

  task automatic run_scan(input logic [N-1:0] d, input int xh,
                          input int xi, input int xc);
    int n;
    data  = d;
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("scan_busy_first", int'(busy), 1);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("scan_latency", n, N + 1);
    chk("scan_hit", int'(hit), xh);
    chk("scan_index", int'(index), xi);
    chk("scan_count", int'(count), xc);
    repeat (5) @(negedge clk);
    chk("hold_done", int'(done), 0);
    chk("hold_hit", int'(hit), xh);
    chk("hold_index", int'(index), xi);
    chk("hold_count", int'(count), xc);
  endtask

  initial begin
    logic [N-1:0] pat;
    int n, gap, dones;
    rst = 1'b1; mode = 1'b0; start = 1'b0; sel = '0; data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    rst = 1'b0;

    // Direct select sweep with ignored start pulses
    pat  = 16'hA5C3;
    data = pat;
    for (int s = 0; s < N; s++) begin
      sel   = W'(s);
      start = s[0];
      @(negedge clk);
      chk("direct_z", int'(z), int'(pat[s]));
      chk("direct_busy", int'(busy), 0);
    end
    start = 1'b0;
    sel = 4'd0;  @(negedge clk); chk("z_bit0", int'(z), 1);
    sel = 4'd2;  @(negedge clk); chk("z_bit2", int'(z), 0);
    sel = 4'd15; @(negedge clk); chk("z_bit15", int'(z), 1);

    run_scan(16'h0120, 1, 5, 2);
    run_scan(16'h0000, 0, 0, 0);
    run_scan(16'hFFFF, 1, 0, 16);
    run_scan(16'h8000, 1, 15, 1);

    // Snapshot isolation: bus and start change during SCAN and DONE
    data = 16'h0008; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    data = 16'hFFFF;
    dones = 0;
    n = 1;
    while (n < 40) begin
      start = n[0];
      if (done) begin
        dones++;
        start = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("iso_done_seen", dones, 1);
    repeat (6) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("iso_one_done", dones, 1);
    chk("iso_index", int'(index), 3);
    chk("iso_count", int'(count), 1);

    // Reset mid-scan, then a clean restart
    data = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_hit", int'(hit), 0);
    chk("mrst_count", int'(count), 0);
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mrst_no_done", dones, 0);
    run_scan(16'h0300, 1, 8, 2);

    // Start held high: scans repeat every N+2 cycles
    data = 16'h0F0F; mode = 1'b1; start = 1'b1;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    gap = 1;
    while (!done && gap < 60) begin
      @(negedge clk);
      gap++;
    end
    start = 1'b0;
    chk("repeat_gap", gap, N + 2);
    chk("repeat_count", int'(count), 8);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
